// File: rtl/dmem_responder.sv
// dmem_responder: shared data-memory target for NUM_CORES load/store ports.
// Round-robin arbitration grants one access per cycle. Stores merge byte/half
// lanes into the addressed word. Loads respond one cycle after grant.
// Optional feature macro: DMEM_LOAD_SIGN_EXT_EN adds req_signed so byte/half
// loads can sign-extend; without it they always zero-extend.
// Handshake: a request transfers on the rising edge where req_valid[i] and
// req_ready[i] are both high; req_ready is combinational, is one-hot or zero,
// and may be raised without waiting for anything but req_valid.
module dmem_responder #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 12
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [NUM_CORES-1:0]   req_valid,
    output logic [NUM_CORES-1:0]   req_ready,
    input  logic [NUM_CORES-1:0]   req_write,
    input  logic [NUM_CORES-1:0]   req_half,
    input  logic [NUM_CORES-1:0]   req_byte,
    input  logic [32*NUM_CORES-1:0] req_addr,
    input  logic [32*NUM_CORES-1:0] req_wdata,
`ifdef DMEM_LOAD_SIGN_EXT_EN
    input  logic [NUM_CORES-1:0]   req_signed,
`endif
    output logic [NUM_CORES-1:0]   rsp_valid,
    output logic [32*NUM_CORES-1:0] rsp_rdata,
    output logic                   misalign,
    output logic                   rsp_state_dbg_o
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        RSP_IDLE   = 1'b0,
        RSP_ACTIVE = 1'b1
    } rsp_state_e;

    rsp_state_e             rsp_state_q;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_CORES-1:0]   rsp_valid_q;
    logic [32*NUM_CORES-1:0] rsp_rdata_q;
    logic                   misalign_q;
    logic [31:0]            mem_q [DEPTH];

    logic                   lo_found, hi_found, gnt_found, fire;
    logic [PTR_W-1:0]       lo_idx, hi_idx, gnt_idx;
    logic [31:0]            g_addr, g_wdata, eff_addr, old_word, merged, load_data;
    logic                   g_write, g_byte, g_half, g_signed, g_mis;
    logic [ADDR_W-1:0]      word_idx;
    logic [7:0]             lane_b;
    logic [15:0]            lane_h;
    logic                   unused_addr_bits;

    // Round-robin: lowest valid index at/after rr_ptr wins, else lowest overall.
    always_comb begin
        lo_found = 1'b0;
        lo_idx   = '0;
        hi_found = 1'b0;
        hi_idx   = '0;
        for (int c = NUM_CORES - 1; c >= 0; c--) begin
            if (req_valid[c]) begin
                lo_found = 1'b1;
                lo_idx   = PTR_W'(c);
                if (PTR_W'(c) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = PTR_W'(c);
                end
            end
        end
        gnt_found = lo_found;
        gnt_idx   = hi_found ? hi_idx : lo_idx;
        fire      = gnt_found && Reset;
        req_ready = '0;
        if (fire) begin
            req_ready[gnt_idx] = 1'b1;
        end
        rr_ptr_d = rr_ptr_q;
        if (fire) begin
            rr_ptr_d = (gnt_idx == PTR_W'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Decode the granted access: alignment, store merge and load lane extract.
    always_comb begin
        g_addr  = req_addr[32*gnt_idx +: 32];
        g_wdata = req_wdata[32*gnt_idx +: 32];
        g_write = req_write[gnt_idx];
        g_byte  = req_byte[gnt_idx];
        g_half  = req_half[gnt_idx] && !g_byte;
`ifdef DMEM_LOAD_SIGN_EXT_EN
        g_signed = req_signed[gnt_idx];
`else
        g_signed = 1'b0;
`endif
        eff_addr = g_addr;
        g_mis    = 1'b0;
        if (g_half) begin
            g_mis       = g_addr[0];
            eff_addr[0] = 1'b0;
        end else if (!g_byte) begin
            g_mis         = (g_addr[1:0] != 2'b00);
            eff_addr[1:0] = 2'b00;
        end
        word_idx = eff_addr[ADDR_W+1:2];
        old_word = mem_q[word_idx];
        lane_b   = old_word[8*eff_addr[1:0] +: 8];
        lane_h   = old_word[16*eff_addr[1] +: 16];
        merged   = old_word;
        if (g_byte) begin
            merged[8*eff_addr[1:0] +: 8] = g_wdata[7:0];
        end else if (g_half) begin
            merged[16*eff_addr[1] +: 16] = g_wdata[15:0];
        end else begin
            merged = g_wdata;
        end
        if (g_byte) begin
            load_data = {{24{g_signed & lane_b[7]}}, lane_b};
        end else if (g_half) begin
            load_data = {{16{g_signed & lane_h[15]}}, lane_h};
        end else begin
            load_data = old_word;
        end
    end

    // Upper byte-address bits are outside the array and deliberately ignored.
    assign unused_addr_bits = ^g_addr[31:ADDR_W+2];

    // Array write port; Reset gating drops a store granted while in reset.
    always_ff @(posedge Clk) begin
        if (fire && g_write) begin
            mem_q[word_idx] <= merged;
        end
    end

    // Response FSM with registered response, pointer and sticky misalign flag.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rsp_state_q <= RSP_IDLE;
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= '0;
            if (fire && g_mis) begin
                misalign_q <= 1'b1;
            end
            if (fire && !g_write) begin
                rsp_valid_q[gnt_idx]          <= 1'b1;
                rsp_rdata_q[32*gnt_idx +: 32] <= load_data;
            end
            case (rsp_state_q)
                RSP_IDLE:   if (fire && !g_write) rsp_state_q <= RSP_ACTIVE;
                RSP_ACTIVE: if (!(fire && !g_write)) rsp_state_q <= RSP_IDLE;
                default:    rsp_state_q <= RSP_IDLE;
            endcase
        end
    end

    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign misalign        = misalign_q;
    assign rsp_state_dbg_o = rsp_state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder (NUM_CORES=2, ADDR_W=12): directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_dmem_responder;

    localparam int N = 2;

    logic          clk;
    logic          Reset;
    logic [N-1:0]  req_valid, req_ready, req_write, req_half, req_byte, req_signed;
    logic [32*N-1:0] req_addr, req_wdata, rsp_rdata;
    logic [N-1:0]  rsp_valid;
    logic          misalign, rsp_state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    logic [31:0] m_mem [4096];
    int          m_rr;
    logic [N-1:0] m_valid;
    logic [31:0] m_rdata [N];
    logic        m_mis;

    dmem_responder #(.NUM_CORES(N), .ADDR_W(12)) dut (
        .Clk(clk),
        .Reset(Reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_half(req_half),
        .req_byte(req_byte),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
`ifdef DMEM_LOAD_SIGN_EXT_EN
        .req_signed(req_signed),
`endif
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .misalign(misalign),
        .rsp_state_dbg_o(rsp_state_dbg)
    );

    // Clock / reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Effective address after alignment rules (byte wins over half).
    function automatic logic [31:0] align_addr(input logic [31:0] a, input logic hf, input logic by);
        if (by) return a;
        if (hf) return a & ~32'd1;
        return a & ~32'd3;
    endfunction

    function automatic logic is_mis(input logic [31:0] a, input logic hf, input logic by);
        if (by) return 1'b0;
        if (hf) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [31:0] a, input logic hf, input logic by);
        int unsigned sh;
        logic [31:0] mask;
        sh = 8 * (a % 4);
        if (by) mask = 32'hFF << sh;
        else if (hf) mask = 32'hFFFF << sh;
        else return wd;
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] a,
                                               input logic hf, input logic by, input logic sg);
        logic [31:0] v;
        logic        sx;
        v = word >> (8 * (a % 4));
        sx = 1'b0;
`ifdef DMEM_LOAD_SIGN_EXT_EN
        sx = sg;
`endif
        if (by) begin
            v = v & 32'hFF;
            if (sx && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (hf) begin
            v = v & 32'hFFFF;
            if (sx && v >= 32'h8000) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    // Compare process: check outputs each cycle, then advance the model.
    always @(negedge clk) begin
        int g;
        logic [31:0] a;
        logic [N-1:0] exp_ready;
        if (!Reset) begin
            chk("rst_ready", {62'd0, req_ready}, 64'd0);
            chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
            chk("rst_rsp_rdata", rsp_rdata, 64'd0);
            chk("rst_misalign", {63'd0, misalign}, 64'd0);
            m_rr = 0;
            m_valid = '0;
            for (int i = 0; i < N; i++) m_rdata[i] = 32'd0;
            m_mis = 1'b0;
        end else begin
            g = -1;
            for (int off = 0; off < N; off++) begin
                int c;
                c = (m_rr + off) % N;
                if (g < 0 && req_valid[c]) g = c;
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", {62'd0, req_ready}, {62'd0, exp_ready});
            chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, m_valid});
            chk("rsp_rdata", rsp_rdata, {m_rdata[1], m_rdata[0]});
            chk("misalign", {63'd0, misalign}, {63'd0, m_mis});
            chk("rsp_state", {63'd0, rsp_state_dbg}, {63'd0, (m_valid != '0)});
            m_valid = '0;
            if (g >= 0) begin
                m_rr = (g + 1) % N;
                a = align_addr(req_addr[32*g +: 32], req_half[g], req_byte[g]);
                if (is_mis(req_addr[32*g +: 32], req_half[g], req_byte[g])) m_mis = 1'b1;
                if (req_write[g]) begin
                    m_mem[(a >> 2) % 4096] = model_merge(m_mem[(a >> 2) % 4096],
                        req_wdata[32*g +: 32], a, req_half[g], req_byte[g]);
                end else begin
                    m_valid[g] = 1'b1;
                    m_rdata[g] = model_load(m_mem[(a >> 2) % 4096], a,
                        req_half[g], req_byte[g], req_signed[g]);
                end
            end
        end
    end

    // Driver: present one request for one cycle (called at posedge+1).
    task automatic issue(input int core, input logic wr, input logic hf, input logic by,
                         input logic sg, input logic [31:0] addr, input logic [31:0] wd);
        req_valid = '0;
        req_valid[core] = 1'b1;
        req_write[core] = wr;
        req_half[core]  = hf;
        req_byte[core]  = by;
        req_signed[core] = sg;
        req_addr[32*core +: 32]  = addr;
        req_wdata[32*core +: 32] = wd;
        @(posedge clk);
        #1;
        req_valid = '0;
    endtask

    logic [1:0] exp_gnt [4];

    initial begin
        Reset = 1'b0;
        req_valid = '0; req_write = '0; req_half = '0; req_byte = '0; req_signed = '0;
        req_addr = '0; req_wdata = '0;
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        Reset = 1'b1;

        // Fill the 32-word working window so every later load is defined.
        for (int w = 0; w < 32; w++) issue(w % N, 1'b1, 1'b0, 1'b0, 1'b0, w * 4, $urandom);

        // Word store then load.
        issue(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'hA1B2C3D4);
        issue(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        chk("t2_valid", {62'd0, rsp_valid}, 64'd1);
        chk("t2_rdata", {32'd0, rsp_rdata[31:0]}, 64'hA1B2C3D4);
        @(posedge clk); #1;
        chk("t2_pulse", {62'd0, rsp_valid}, 64'd0);

        // Byte store merge and half load on the other core.
        issue(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h11, 32'h000000EE);
        issue(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        chk("t3_lw", {32'd0, rsp_rdata[31:0]}, 64'hA1B2EED4);
        issue(1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h12, 32'h0);
`ifdef DMEM_LOAD_SIGN_EXT_EN
        chk("t3_lh", {32'd0, rsp_rdata[63:32]}, 64'hFFFFA1B2);
`else
        chk("t3_lh", {32'd0, rsp_rdata[63:32]}, 64'h0000A1B2);
`endif
        chk("t3_hold0", {32'd0, rsp_rdata[31:0]}, 64'hA1B2EED4);
        chk("t3_valid1", {62'd0, rsp_valid}, 64'd2);

        // Store then load on consecutive cycles.
        issue(1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h12345678);
        issue(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
        chk("t5_rdata", {32'd0, rsp_rdata[63:32]}, 64'h12345678);
        chk("t5_no_mis", {63'd0, misalign}, 64'd0);

        // Misaligned half load.
        issue(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h13, 32'h0);
        chk("t6_rdata", {32'd0, rsp_rdata[31:0]}, 64'h0000A1B2);
        chk("t6_mis", {63'd0, misalign}, 64'd1);
        issue(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
        issue(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h24, 32'h55AA55AA);
        chk("t6_sticky", {63'd0, misalign}, 64'd1);

        // Reset mid-transaction: load response dropped, pending store ignored.
        req_valid = 2'b01; req_write = 2'b00; req_half = '0; req_byte = '0;
        req_addr[31:0] = 32'h10;
        @(posedge clk); #1;
        req_write[0] = 1'b1; req_wdata[31:0] = 32'hDEADBEEF;
        #1 Reset = 1'b0;
        #1;
        chk("t1_valid", {62'd0, rsp_valid}, 64'd0);
        chk("t1_rdata", rsp_rdata, 64'd0);
        chk("t1_mis", {63'd0, misalign}, 64'd0);
        chk("t1_ready", {62'd0, req_ready}, 64'd0);
        @(posedge clk); #1;
        chk("t1_no_rsp", {62'd0, rsp_valid}, 64'd0);
        req_valid = '0; req_write = '0;
        Reset = 1'b1;
        #1;

        // Round-robin from rr_ptr=0 with both cores loading.
        req_valid = 2'b11; req_write = 2'b00;
        req_addr = {32'h20, 32'h10};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_grant", {62'd0, req_ready}, {62'd0, exp_gnt[k]});
            if (k > 0) chk("t4_rsp", {62'd0, rsp_valid}, {62'd0, exp_gnt[k-1]});
            @(posedge clk); #1;
        end
        req_valid = '0;
        issue(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        chk("t1_store_dropped", {32'd0, rsp_rdata[31:0]}, 64'hA1B2EED4);

        // Randomized traffic, one mid-run reset.
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < N; c++) begin
                req_valid[c]  = ($urandom_range(0, 3) != 0);
                req_write[c]  = $urandom_range(0, 1);
                req_half[c]   = $urandom_range(0, 1);
                req_byte[c]   = ($urandom_range(0, 2) == 0);
                req_signed[c] = $urandom_range(0, 1);
                req_addr[32*c +: 32] = ($urandom & 32'hFFFFC000)
                                     | (32'($urandom_range(0, 31)) << 2)
                                     | 32'($urandom_range(0, 3));
                req_wdata[32*c +: 32] = $urandom;
            end
            if (cyc == 300) Reset = 1'b0;
            if (cyc == 303) Reset = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
